// File: rtl/pulse_chain_gen.sv
// Multi-channel optical pulse sequencer. Each channel produces one delayed pulse per trigger,
// either timed from the trigger itself or chained off the falling edge of the previous channel.
module pulse_chain_gen #(
  parameter int NCH = 4,
  parameter int CW  = 36
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           trig,
  input  logic           abort,
  input  logic           cfg_we,
  input  logic [3:0]     cfg_ch,
  input  logic [1:0]     cfg_sel,
  input  logic [CW-1:0]  cfg_data,
  output logic [NCH-1:0] pulse_out,
  output logic           busy,
  output logic           done,
  output logic           overrun
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DELAY, S_PULSE, S_FIN} state_t;

  logic [CW-1:0] r_sh_delay [NCH];
  logic [CW-1:0] r_sh_width [NCH];
  logic [1:0]    r_sh_mode  [NCH];
  logic [CW-1:0] r_act_delay [NCH];
  logic [CW-1:0] r_act_width [NCH];
  logic [1:0]    r_act_mode  [NCH];

  state_t        r_state     [NCH];
  state_t        w_state_nxt [NCH];
  logic [CW-1:0] r_cnt       [NCH];
  logic [CW-1:0] w_cnt_nxt   [NCH];
  logic [NCH-1:0] w_end;

  logic [1:0] r_rst_sync;
  logic       r_trig_d;
  logic       r_first;
  logic       r_done;
  logic       r_overrun;
  logic       w_busy;
  logic       w_all_fin;
  logic       w_trig_edge;
  logic       w_accept;
  logic       w_ovr_set;
  logic       w_ovr_clr;
  logic       w_cfg_ok;

  always_comb begin
    w_busy    = 1'b0;
    w_all_fin = 1'b1;
    for (int k = 0; k < NCH; k++) begin
      if (r_state[k] != S_IDLE) w_busy = 1'b1;
      if (r_state[k] != S_FIN)  w_all_fin = 1'b0;
    end
  end

  // r_rst_sync[1] gates triggers until two edges after reset release.
  assign w_trig_edge = trig & ~r_trig_d;
  assign w_accept    = w_trig_edge & ~w_busy & ~abort & r_rst_sync[1];
  assign w_ovr_set   = w_trig_edge & w_busy & ~abort;
  assign w_cfg_ok    = cfg_we & ({28'd0, cfg_ch} < 32'(NCH));
  assign w_ovr_clr   = w_cfg_ok & (cfg_sel == 2'd3);

  // w_chain carries "previous channel ends at this edge"; r_first seeds it at E0+1.
  always_comb begin
    logic w_chain;
    logic w_start;
    w_chain = r_first;
    w_start = 1'b0;
    w_end   = '0;
    for (int k = 0; k < NCH; k++) begin
      w_state_nxt[k] = r_state[k];
      w_cnt_nxt[k]   = r_cnt[k];
      w_start        = r_act_mode[k][0] ? r_first : w_chain;
      case (r_state[k])
        S_IDLE: begin
          if (w_accept) begin
            w_state_nxt[k] = (r_sh_mode[k] != 2'b00) ? S_WAIT : S_FIN;
            w_cnt_nxt[k]   = '0;
          end
        end
        S_WAIT: begin
          if (w_start) begin
            if (r_act_delay[k] != '0) begin
              w_state_nxt[k] = S_DELAY;
              w_cnt_nxt[k]   = r_act_delay[k];
            end else if (r_act_width[k] != '0) begin
              w_state_nxt[k] = S_PULSE;
              w_cnt_nxt[k]   = r_act_width[k];
            end else begin
              w_state_nxt[k] = S_FIN;
              w_end[k]       = 1'b1;
            end
          end
        end
        S_DELAY: begin
          if (r_cnt[k] == CW'(1)) begin
            if (r_act_width[k] != '0) begin
              w_state_nxt[k] = S_PULSE;
              w_cnt_nxt[k]   = r_act_width[k];
            end else begin
              w_state_nxt[k] = S_FIN;
              w_cnt_nxt[k]   = '0;
              w_end[k]       = 1'b1;
            end
          end else begin
            w_cnt_nxt[k] = r_cnt[k] - CW'(1);
          end
        end
        S_PULSE: begin
          if (r_cnt[k] == CW'(1)) begin
            w_state_nxt[k] = S_FIN;
            w_cnt_nxt[k]   = '0;
            w_end[k]       = 1'b1;
          end else begin
            w_cnt_nxt[k] = r_cnt[k] - CW'(1);
          end
        end
        S_FIN: begin
          // A disabled channel passes the chain through with zero latency.
          if (r_act_mode[k] == 2'b00) w_end[k] = w_start;
          if (w_all_fin) w_state_nxt[k] = S_IDLE;
        end
        default: w_state_nxt[k] = S_IDLE;
      endcase
      if (abort && w_busy) begin
        w_state_nxt[k] = S_IDLE;
        w_cnt_nxt[k]   = '0;
      end
      w_chain = w_end[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_sync <= 2'b00;
      r_trig_d   <= 1'b0;
      r_first    <= 1'b0;
      r_done     <= 1'b0;
      r_overrun  <= 1'b0;
      for (int k = 0; k < NCH; k++) begin
        r_state[k]     <= S_IDLE;
        r_cnt[k]       <= '0;
        r_sh_delay[k]  <= '0;
        r_sh_width[k]  <= '0;
        r_sh_mode[k]   <= 2'b00;
        r_act_delay[k] <= '0;
        r_act_width[k] <= '0;
        r_act_mode[k]  <= 2'b00;
      end
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
      r_trig_d   <= trig;
      r_first    <= w_accept;
      r_done     <= w_all_fin & ~abort;
      if (w_ovr_set)      r_overrun <= 1'b1;
      else if (w_ovr_clr) r_overrun <= 1'b0;
      for (int k = 0; k < NCH; k++) begin
        r_state[k] <= w_state_nxt[k];
        r_cnt[k]   <= w_cnt_nxt[k];
        if (w_cfg_ok && (cfg_ch == 4'(k))) begin
          case (cfg_sel)
            2'd0:    r_sh_delay[k] <= cfg_data;
            2'd1:    r_sh_width[k] <= cfg_data;
            2'd2:    r_sh_mode[k]  <= cfg_data[1:0];
            default: ;
          endcase
        end
        if (w_accept) begin
          r_act_delay[k] <= r_sh_delay[k];
          r_act_width[k] <= r_sh_width[k];
          r_act_mode[k]  <= r_sh_mode[k];
        end
      end
    end
  end

  always_comb begin
    pulse_out = '0;
    for (int k = 0; k < NCH; k++) pulse_out[k] = (r_state[k] == S_PULSE);
  end

  assign busy    = w_busy;
  assign done    = r_done;
  assign overrun = r_overrun;

endmodule

// File: tb/tb_pulse_chain_gen.sv
// Bench for pulse_chain_gen: table of channel configurations run against a timing model,
// plus hand-written sequences for overrun, rewrite-while-busy, abort and reset corners.
module tb_pulse_chain_gen;

  localparam int NCH = 4;
  localparam int CW  = 36;

  typedef struct {
    logic [1:0] mode [NCH];
    int         d    [NCH];
    int         w    [NCH];
    int         exp_done;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           trig = 1'b0;
  logic           abort = 1'b0;
  logic           cfg_we = 1'b0;
  logic [3:0]     cfg_ch = 4'd0;
  logic [1:0]     cfg_sel = 2'd0;
  logic [CW-1:0]  cfg_data = '0;
  logic [NCH-1:0] pulse_out;
  logic           busy;
  logic           done;
  logic           overrun;

  int n_vec = 0;
  int n_err = 0;
  logic [NCH+1:0] exp_q[$];
  vec_t tbl [6];

  pulse_chain_gen #(.NCH(NCH), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .trig(trig), .abort(abort),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .pulse_out(pulse_out), .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string name, input int c, input logic [NCH+1:0] got,
                           input logic [NCH+1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s c=%0d {done,busy,pulse} got=%b exp=%b", name, c, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Timing model: S=1 for triggered channels, S=end of previous for chained; rise=S+D, fall=rise+W.
  function automatic int model_last(input vec_t v);
    int prev, s, last;
    prev = 1;
    last = 0;
    for (int k = 0; k < NCH; k++) begin
      if (v.mode[k] != 2'b00) begin
        s    = v.mode[k][0] ? 1 : prev;
        prev = s + v.d[k] + v.w[k];
        if (prev > last) last = prev;
      end
    end
    return last;
  endfunction

  function automatic logic [NCH+1:0] model_at(input vec_t v, input int c);
    int prev, s, rise, fall, last;
    logic [NCH-1:0] p;
    prev = 1;
    p    = '0;
    for (int k = 0; k < NCH; k++) begin
      if (v.mode[k] != 2'b00) begin
        s    = v.mode[k][0] ? 1 : prev;
        rise = s + v.d[k];
        fall = rise + v.w[k];
        prev = fall;
        p[k] = (c >= rise) && (c < fall);
      end
    end
    last = model_last(v);
    return {(c == last + 1), (c <= last), p};
  endfunction

  task automatic cfg_write(input int ch, input int sel, input int data);
    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_ch   = 4'(ch);
    cfg_sel  = 2'(sel);
    cfg_data = CW'(data);
    @(negedge clk);
    cfg_we   = 1'b0;
  endtask

  task automatic load_cfg(input vec_t v);
    for (int k = 0; k < NCH; k++) begin
      cfg_write(k, 2, int'(v.mode[k]));
      cfg_write(k, 0, v.d[k]);
      cfg_write(k, 1, v.w[k]);
    end
  endtask

  // Trigger one run; optional retrigger, ch0 width rewrite and abort at sample index c.
  task automatic run_vec(input string name, input vec_t v, input int retrig_c,
                         input int rewrite_c, input int abort_c);
    int n, last, done_c;
    logic [NCH+1:0] got, e;
    last = model_last(v);
    n = (abort_c >= 0) ? abort_c + 4 : last + 3;
    for (int c = 0; c < n; c++)
      exp_q.push_back((abort_c >= 0 && c > abort_c) ? '0 : model_at(v, c));
    @(negedge clk);
    trig   = 1'b1;
    done_c = -1;
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      got = {done, busy, pulse_out};
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL %s c=%0d expected queue empty", name, c);
      end else begin
        e = exp_q.pop_front();
        check_vec(name, c, got, e);
      end
      if (done === 1'b1 && done_c < 0) done_c = c;
      trig  = (c == retrig_c);
      abort = (c == abort_c);
      if (c == rewrite_c) begin
        cfg_we = 1'b1; cfg_ch = 4'd0; cfg_sel = 2'd1; cfg_data = CW'(9);
      end else begin
        cfg_we = 1'b0;
      end
    end
    trig = 1'b0; abort = 1'b0; cfg_we = 1'b0;
    if (v.exp_done >= 0 && abort_c < 0) check_int({name, "_done_cycle"}, done_c, v.exp_done);
  endtask

  initial begin
    #400000;
    n_err++;
    $display("FAIL watchdog time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    vec_t v;
    tbl[0].mode = '{2'b01, 2'b00, 2'b00, 2'b00};
    tbl[0].d = '{3, 0, 0, 0}; tbl[0].w = '{5, 0, 0, 0}; tbl[0].exp_done = 10;
    tbl[1].mode = '{2'b01, 2'b10, 2'b10, 2'b00};
    tbl[1].d = '{0, 0, 2, 0}; tbl[1].w = '{2, 3, 1, 0}; tbl[1].exp_done = 10;
    tbl[2].mode = '{2'b01, 2'b00, 2'b10, 2'b00};
    tbl[2].d = '{1, 5, 0, 0}; tbl[2].w = '{2, 5, 2, 0}; tbl[2].exp_done = 7;
    tbl[3].mode = '{2'b00, 2'b00, 2'b00, 2'b00};
    tbl[3].d = '{2, 2, 2, 2}; tbl[3].w = '{2, 2, 2, 2}; tbl[3].exp_done = 1;
    tbl[4].mode = '{2'b01, 2'b10, 2'b11, 2'b10};
    tbl[4].d = '{2, 0, 1, 0}; tbl[4].w = '{0, 3, 1, 0}; tbl[4].exp_done = 7;
    tbl[5].mode = '{2'b01, 2'b01, 2'b11, 2'b10};
    tbl[5].d = '{4, 0, 2, 1}; tbl[5].w = '{1, 1, 2, 3}; tbl[5].exp_done = 10;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_vec("reset_outputs", 0, {overrun, done, busy, pulse_out[NCH-2:0]}, '0);
    check_int("reset_pulse_top", int'(pulse_out[NCH-1]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      load_cfg(tbl[i]);
      run_vec($sformatf("tbl%0d", i), tbl[i], -1, -1, -1);
    end

    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < NCH; k++) begin
        v.mode[k] = 2'($urandom_range(0, 3));
        v.d[k]    = $urandom_range(0, 4);
        v.w[k]    = $urandom_range(0, 4);
      end
      v.exp_done = -1;
      load_cfg(v);
      run_vec($sformatf("rand%0d", i), v, -1, -1, -1);
    end

    // Retrigger mid-run: run unaffected, overrun sticky, cleared only by an in-range sel=3 write
    load_cfg(tbl[0]);
    run_vec("overrun_run", tbl[0], 3, -1, -1);
    check_int("overrun_set", int'(overrun), 1);
    cfg_write(8, 3, 0);
    check_int("overrun_clr_out_of_range", int'(overrun), 1);
    cfg_write(0, 3, 0);
    check_int("overrun_clr", int'(overrun), 0);

    // Trigger edge on the edge where done fires
    run_vec("trig_on_done", tbl[0], 9, -1, -1);
    check_int("trig_on_done_overrun", int'(overrun), 1);
    cfg_write(0, 3, 0);

    // Width rewrite while busy lands on the following run
    run_vec("rewrite_old", tbl[0], -1, 2, -1);
    v = tbl[0];
    v.w[0] = 9;
    v.exp_done = 14;
    run_vec("rewrite_new", v, -1, -1, -1);

    // Abort during ch1 pulse
    load_cfg(tbl[1]);
    run_vec("abort", tbl[1], -1, -1, 3);

    // Trigger coincident with abort while idle
    @(negedge clk);
    abort = 1'b1;
    trig  = 1'b1;
    @(posedge clk);
    #1;
    check_int("abort_trig_busy", int'(busy), 0);
    check_int("abort_trig_overrun", int'(overrun), 0);
    abort = 1'b0;
    trig  = 1'b0;
    @(posedge clk);
    #1;
    check_int("abort_trig_busy_after", int'(busy), 0);

    // Asynchronous reset mid-pulse, then trigger held across release
    load_cfg(tbl[0]);
    @(negedge clk);
    trig = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    trig = 1'b0;
    check_int("pre_reset_pulse", int'(pulse_out), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_int("async_reset_pulse", int'(pulse_out), 0);
    check_int("async_reset_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    trig  = 1'b1;
    @(posedge clk);
    #1;
    check_int("release_edge1_busy", int'(busy), 0);
    @(posedge clk);
    #1;
    check_int("release_edge2_busy", int'(busy), 0);
    trig = 1'b0;
    repeat (2) @(negedge clk);
    load_cfg(tbl[0]);
    run_vec("post_reset", tbl[0], -1, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
